// File: rtl/timer_poller.sv
// MMIO timer poller: programs limit/count/control registers, then polls
// the control/status register and acknowledges READY events.
module timer_poller #(
  parameter logic [31:0] TCNT_ADDR     = 32'hF0000020,
  parameter logic [31:0] TLIM_ADDR     = 32'hF0000024,
  parameter logic [31:0] TCTL_ADDR     = 32'hF0000120,
  parameter int          READY_BIT     = 0,
  parameter int          OVERRUN_BIT   = 2,
  parameter logic [31:0] POLL_INTERVAL = 32'd100
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bus_abus,
  output logic        bus_wren,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        cfg_start,
  input  logic [31:0] cfg_lim,
  input  logic        cfg_stop,
  input  logic        overrun_clr,
  output logic        busy,
  output logic        tick,
  output logic [31:0] tick_count,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_LIM,
    S_CFG_CNT,
    S_CFG_CTL,
    S_WAIT,
    S_POLL,
    S_CLEAR
  } state_t;

  state_t      state, state_d;
  logic [31:0] cnt;
  logic [31:0] lim;
  logic        ovr_pend;
  logic        load_lim;
  logic        load_cnt;
  logic        dec_cnt;

  always_comb begin
    bus_abus = '0;
    bus_wren = 1'b0;
    bus_dout = '0;
    busy     = (state != S_IDLE);
    tick     = 1'b0;
    unique case (state)
      S_CFG_LIM: begin
        bus_abus = TLIM_ADDR;
        bus_wren = 1'b1;
        bus_dout = lim;
      end
      S_CFG_CNT: begin
        bus_abus = TCNT_ADDR;
        bus_wren = 1'b1;
      end
      S_CFG_CTL: begin
        bus_abus = TCTL_ADDR;
        bus_wren = 1'b1;
      end
      S_POLL: bus_abus = TCTL_ADDR;
      S_CLEAR: begin
        bus_abus = TCTL_ADDR;
        bus_wren = 1'b1;
        tick     = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state;
    load_lim = 1'b0;
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_d  = S_CFG_LIM;
          load_lim = 1'b1;
        end
      end
      S_CFG_LIM: state_d = S_CFG_CNT;
      S_CFG_CNT: state_d = S_CFG_CTL;
      S_CFG_CTL: begin
        state_d  = S_WAIT;
        load_cnt = 1'b1;
      end
      S_WAIT: begin
        // start outranks stop when both arrive together
        if (cfg_start) begin
          state_d  = S_CFG_LIM;
          load_lim = 1'b1;
        end else if (cfg_stop) begin
          state_d = S_IDLE;
        end else if (cnt == 32'd0) begin
          state_d = S_POLL;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      S_POLL: begin
        load_cnt = 1'b1;
        state_d  = bus_din[READY_BIT] ? S_CLEAR : S_WAIT;
      end
      S_CLEAR: begin
        state_d  = S_WAIT;
        load_cnt = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      lim        <= '0;
      tick_count <= '0;
      overrun    <= 1'b0;
      ovr_pend   <= 1'b0;
    end else begin
      state <= state_d;
      if (load_lim) lim <= cfg_lim;
      if (load_cnt) cnt <= POLL_INTERVAL - 32'd1;
      else if (dec_cnt) cnt <= cnt - 32'd1;
      if (state == S_POLL && bus_din[READY_BIT])
        ovr_pend <= bus_din[OVERRUN_BIT];
      if (state == S_CLEAR) tick_count <= tick_count + 32'd1;
      // a set in the same cycle as a clear request wins
      if (state == S_CLEAR && ovr_pend) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_poller.sv
// Randomised and directed bench for timer_poller, checked against a
// schedule-of-bus-operations model.
module tb_timer_poller;

  localparam logic [31:0] TCNT = 32'hF0000020;
  localparam logic [31:0] TLIM = 32'hF0000024;
  localparam logic [31:0] TCTL = 32'hF0000120;
  localparam int          PI   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_abus;
  logic        bus_wren;
  logic [31:0] bus_dout;
  logic [31:0] bus_din = '0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_lim = '0;
  logic        cfg_stop = 1'b0;
  logic        overrun_clr = 1'b0;
  logic        busy;
  logic        tick;
  logic [31:0] tick_count;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  timer_poller #(
    .TCNT_ADDR(TCNT),
    .TLIM_ADDR(TLIM),
    .TCTL_ADDR(TCTL),
    .READY_BIT(0),
    .OVERRUN_BIT(2),
    .POLL_INTERVAL(32'(PI))
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_abus(bus_abus),
    .bus_wren(bus_wren),
    .bus_dout(bus_dout),
    .bus_din(bus_din),
    .cfg_start(cfg_start),
    .cfg_lim(cfg_lim),
    .cfg_stop(cfg_stop),
    .overrun_clr(overrun_clr),
    .busy(busy),
    .tick(tick),
    .tick_count(tick_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Model: a queue of the bus operations scheduled for upcoming cycles.
  // kind: 1 config write, 2 wait, 3 poll, 4 clear
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic        ovp;
  } op_t;

  op_t         q[$];
  bit          m_active = 0;
  logic [31:0] m_tc = '0;
  logic        m_ov = 1'b0;

  function automatic op_t mk(int k, logic [31:0] a, logic w,
                             logic [31:0] d, logic ovp);
    op_t o;
    o.kind = k; o.a = a; o.w = w; o.d = d; o.ovp = ovp;
    return o;
  endfunction

  task automatic sched_cfg(logic [31:0] l);
    q.delete();
    q.push_back(mk(1, TLIM, 1'b1, l, 1'b0));
    q.push_back(mk(1, TCNT, 1'b1, '0, 1'b0));
    q.push_back(mk(1, TCTL, 1'b1, '0, 1'b0));
    m_active = 1;
  endtask

  task automatic model_edge();
    op_t h;
    bit  set_ov;
    set_ov = 0;
    if (rst) begin
      q.delete();
      m_active = 0;
      m_tc = '0;
      m_ov = 1'b0;
      return;
    end
    if (!m_active) begin
      if (cfg_start) sched_cfg(cfg_lim);
    end else begin
      h = q[0];
      if (h.kind == 2 && cfg_start) sched_cfg(cfg_lim);
      else if (h.kind == 2 && cfg_stop) begin
        q.delete();
        m_active = 0;
      end else begin
        void'(q.pop_front());
        if (h.kind == 3 && bus_din[0])
          q.push_front(mk(4, TCTL, 1'b1, '0, bus_din[2]));
        if (h.kind == 4) begin
          m_tc = m_tc + 1;
          set_ov = h.ovp;
        end
      end
    end
    if (set_ov) m_ov = 1'b1;
    else if (overrun_clr) m_ov = 1'b0;
    if (m_active && q.size() == 0) begin
      for (int i = 0; i < PI; i++) q.push_back(mk(2, '0, 1'b0, '0, 1'b0));
      q.push_back(mk(3, TCTL, 1'b0, '0, 1'b0));
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare();
    op_t h;
    h = mk(0, '0, 1'b0, '0, 1'b0);
    if (m_active) h = q[0];
    chk("abus", bus_abus, h.a);
    chk("wren", 32'(bus_wren), 32'(h.w));
    chk("dout", bus_dout, h.d);
    chk("busy", 32'(busy), 32'(m_active));
    chk("tick", 32'(tick), 32'(h.kind == 4));
    chk("tick_count", tick_count, m_tc);
    chk("overrun", 32'(overrun), 32'(m_ov));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare();
  endtask

  function automatic bit in_poll();
    return bus_abus == TCTL && !bus_wren;
  endfunction

  task automatic goto_poll();
    int n;
    n = 0;
    while (!in_poll() && n < 10) begin
      step();
      n++;
    end
    chk("reach_poll", 32'(in_poll()), 32'd1);
  endtask

  int last_poll;
  int npoll;

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_abus", bus_abus, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tc", tick_count, 32'd0);
    chk("rst_ov", 32'(overrun), 32'd0);

    cfg_lim = 32'd5;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("cfg1_a", bus_abus, 32'hF0000024);
    chk("cfg1_d", bus_dout, 32'd5);
    chk("cfg1_w", 32'(bus_wren), 32'd1);
    step();
    chk("cfg2_a", bus_abus, 32'hF0000020);
    chk("cfg2_d", bus_dout, 32'd0);
    step();
    chk("cfg3_a", bus_abus, 32'hF0000120);
    chk("cfg3_w", 32'(bus_wren), 32'd1);
    step();
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_w", 32'(bus_wren), 32'd0);

    bus_din = '0;
    last_poll = -1;
    npoll = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("idle_tick", 32'(tick), 32'd0);
      if (in_poll()) begin
        if (last_poll >= 0) chk("poll_gap", 32'(cyc - last_poll), 32'd4);
        last_poll = cyc;
        npoll++;
      end
    end
    chk("poll_seen", 32'(npoll >= 3), 32'd1);

    goto_poll();
    bus_din = 32'h1;
    step();
    bus_din = '0;
    chk("rdy_tick", 32'(tick), 32'd1);
    chk("rdy_a", bus_abus, 32'hF0000120);
    chk("rdy_w", 32'(bus_wren), 32'd1);
    step();
    chk("rdy_tc", tick_count, 32'd1);
    chk("rdy_ov", 32'(overrun), 32'd0);

    goto_poll();
    bus_din = 32'h5;
    step();
    bus_din = '0;
    chk("ovr_tick", 32'(tick), 32'd1);
    overrun_clr = 1'b1;
    step();
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_tc", tick_count, 32'd2);
    step();
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'd0);

    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_a", bus_abus, 32'h0);

    cfg_lim = 32'd7;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    step();
    step();
    step();
    cfg_lim = 32'd9;
    cfg_start = 1'b1;
    cfg_stop = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_stop = 1'b0;
    chk("both_a", bus_abus, 32'hF0000024);
    chk("both_d", bus_dout, 32'd9);
    step();
    step();
    step();

    goto_poll();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    chk("poll_ign_w", 32'(bus_wren), 32'd0);
    chk("poll_ign_a", bus_abus, 32'h0);
    chk("poll_ign_busy", 32'(busy), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      cfg_start = ($urandom_range(15) == 0);
      cfg_stop = ($urandom_range(15) == 0);
      overrun_clr = ($urandom_range(7) == 0);
      cfg_lim = $urandom;
      bus_din = $urandom;
      bus_din[0] = ($urandom_range(2) == 0);
      bus_din[2] = ($urandom_range(1) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
